// File: rtl/booth_r4_mult_seq.sv
// Sequential radix-4 Booth multiplier.
// Recodes the multiplier one radix-4 digit per clock. Each digit selects 0, +-1 or +-2
// times the multiplicand, and that partial product is added into a 2*WIDTH+2 bit
// accumulator. The multiplicand is pre-extended and shifted left by two bits after every
// digit, so the accumulator never needs a variable shifter.
module booth_r4_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               signed_mode_i,
  input  logic [WIDTH-1:0]   a_in_i,
  input  logic [WIDTH-1:0]   b_in_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               busy_o,
  output logic               dig_valid_o,
  output logic [2:0]         dig_code_o
);

  localparam int ACC_W = 2*WIDTH + 2;
  localparam int BX_W  = WIDTH + 3;
  localparam int CNT_W = $clog2(WIDTH/2 + 1);
  localparam logic [CNT_W-1:0] LAST_SIGNED   = CNT_W'(WIDTH/2 - 1);
  localparam logic [CNT_W-1:0] LAST_UNSIGNED = CNT_W'(WIDTH/2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   mcand_q, mcand_d;
  logic [BX_W-1:0]    mplier_q, mplier_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               dig_neg, dig_two, dig_one;
  logic [ACC_W-1:0]   pp_mag, pp;
  logic               last_digit;
  logic               unused_acc_top;

  // The mplier register holds {2'b00, b, 1'b0}, so its low three bits are always the
  // current digit triple (b[2i+1], b[2i], b[2i-1]) with b[-1] = 0. The two zero bits on
  // top provide the extra digit that unsigned mode needs.
  assign last_digit     = (cnt_q == (mode_q ? LAST_SIGNED : LAST_UNSIGNED));
  assign product_o      = acc_q[2*WIDTH-1:0];
  assign unused_acc_top = ^acc_q[ACC_W-1:2*WIDTH];

  // Booth recoding of the current triple into {neg, two, one}. Triple 111 is zero, so
  // neg is never set for a zero digit.
  always_comb begin
    dig_neg = 1'b0;
    dig_two = 1'b0;
    dig_one = 1'b0;
    case (mplier_q[2:0])
      3'b001, 3'b010: dig_one = 1'b1;
      3'b011:         dig_two = 1'b1;
      3'b100:         begin dig_two = 1'b1; dig_neg = 1'b1; end
      3'b101, 3'b110: begin dig_one = 1'b1; dig_neg = 1'b1; end
      default:        ;
    endcase
  end

  // Partial product: the already-shifted multiplicand, times one or two, then negated
  // when the digit is negative.
  always_comb begin
    pp_mag = '0;
    if (dig_two)
      pp_mag = mcand_q << 1;
    else if (dig_one)
      pp_mag = mcand_q;
    pp = dig_neg ? (~pp_mag + 1'b1) : pp_mag;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic. The return from DONE to IDLE takes one full cycle, so no new
  // operand set can be accepted on the same edge as the out_ready handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i)  state_d = RUN;
      RUN:     if (last_digit)  state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the registered state. The digit code is shown only while running.
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    busy_o      = (state_q == RUN) || (state_q == DONE);
    out_valid_o = (state_q == DONE);
    dig_valid_o = (state_q == RUN);
    dig_code_o  = (state_q == RUN) ? {dig_neg, dig_two, dig_one} : 3'b000;
  end

  // Datapath next values. Operands are captured and extended at accept. Each RUN cycle
  // adds one partial product, moves the multiplicand up one radix-4 position, and moves
  // the next multiplier triple into the low bits.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          acc_d    = '0;
          cnt_d    = '0;
          mode_d   = signed_mode_i;
          mcand_d  = signed_mode_i ? {{(ACC_W-WIDTH){a_in_i[WIDTH-1]}}, a_in_i}
                                   : {{(ACC_W-WIDTH){1'b0}}, a_in_i};
          mplier_d = {2'b00, b_in_i, 1'b0};
        end
      end
      RUN: begin
        acc_d    = acc_q + pp;
        cnt_d    = cnt_q + CNT_W'(1);
        mcand_d  = mcand_q << 2;
        mplier_d = mplier_q >> 2;
      end
      default: ;
    endcase
  end

  // Datapath registers. An async reset clears everything, which aborts any transaction
  // in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: doc/booth_r4_mult_seq.md
Name: booth_r4_mult_seq

Overview:
- Sequential radix-4 Booth multiplier, parametrised in operand width. Successor to the fixed 8-bit combinational Booth radix-4 encoder.
- Recodes the multiplier one radix-4 digit per clock and accumulates shifted partial products of the multiplicand.
- Supports signed and unsigned operand modes, with valid/ready handshakes on input and output.
- Sits in the arithmetic datapath. A per-cycle digit trace is exported for encoder-level checking.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 4.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- signed_mode  input  1  1 = both operands two's complement; 0 = both unsigned. Sampled at accept.
- a_in  input  WIDTH  multiplicand.
- b_in  input  WIDTH  multiplier, Booth-recoded.
- out_valid  output  1  product available.
- out_ready  input  1  consumer takes product.
- product  output  2*WIDTH  result, two's complement if signed, unsigned otherwise.
- busy  output  1  high in RUN or DONE.
- dig_valid  output  1  dig_code is meaningful this cycle.
- dig_code  output  3  current Booth digit, {neg, two, one}.

Behaviour:
- Reset values (async, on rst_n low): state IDLE, in_ready 1, out_valid 0, busy 0, dig_valid 0, dig_code 000, product 0, internal accumulator and counter 0.
- Reset mid-operation aborts the transaction with no output. The next transaction after release is unaffected.
- Digit count NDIG:
  - Signed mode: WIDTH/2. Multiplier used as is; multiplicand sign-extended.
  - Unsigned mode: WIDTH/2+1. Multiplier zero-extended by 2 bits; multiplicand zero-extended.
- Digit i is taken from bits (b[2i+1], b[2i], b[2i-1]), with b[-1]=0. Value = -2*b[2i+1] + b[2i] + b[2i-1], range -2..+2.
- Digit code mapping:
  - +1 → 001, +2 → 010, -1 → 101, -2 → 110.
  - 0 → 000, including triple 111; neg is never set for zero.
- FSM:
  - IDLE: in_ready=1. On in_valid: latch a, b, mode; clear accumulator and counter; go to RUN.
  - RUN: one digit per cycle. acc += digit * a_ext << (2*cnt); cnt++. dig_valid=1 and dig_code = digit cnt, combinational from registered state. After digit NDIG-1, go to DONE.
  - DONE: out_valid=1, product = acc[2*WIDTH-1:0], held stable. On out_ready, go to IDLE; out_valid drops next cycle.
- Accumulator is internally 2*WIDTH+2 bits, sign-correct. Product is its low 2*WIDTH bits and never overflows for any legal operands.
- Latency: out_valid is high NDIG cycles after the accept edge. WIDTH=8: 4 cycles signed, 5 cycles unsigned.
- Throughput: one op per NDIG+2 cycles when out_ready is held high.
- in_ready=0 in RUN and DONE. in_valid, a_in, b_in and signed_mode are ignored outside IDLE.
- No back-to-back accept in the same cycle as the out_ready handshake.
- dig_valid=0 outside RUN.

Test Plan:
- Signed, a=0xFD (-3), b=0x07:
  - dig_code sequence 101, 010, 000, 000.
  - out_valid 4 cycles after accept; product = 0xFFEB (-21).
- Signed, a=0x80, b=0x80:
  - digits 000, 000, 000, 110.
  - product = 0x4000.
- Signed, a=0x7F, b=0xFF:
  - digits 101, 000, 000, 000.
  - product = 0xFF81 (-127).
- Unsigned, a=0xFF, b=0xFF:
  - 5 RUN cycles, digits 101, 000, 000, 000, 001.
  - product = 0xFE01.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid and a_in.
  - product stays stable and in_ready stays 0.
  - Release out_ready: in_ready returns 1 the next cycle.
- Reset: assert rst_n=0 after 2 RUN cycles.
  - All outputs go to reset values immediately.
  - After release, signed 0x05 × 0x03 → 0x000F.
